// File: rtl/cnt_ext_snap_if.sv
// cnt_ext_snap_if: low-counter inputs and snapshot handshake for cnt_ext_snap
interface cnt_ext_snap_if #(
    parameter int N = 17,
    parameter int M = 32
);
    logic [N-1:0]   lo_cnt;
    logic           lo_cout;
    logic           snap_req;
    logic           snap_busy;
    logic           snap_valid;
    logic [N+M-1:0] snap_val;
    logic           hi_ovf;
    modport master (output lo_cnt, lo_cout, snap_req, input snap_busy, snap_valid, snap_val, hi_ovf);
    modport slave (input lo_cnt, lo_cout, snap_req, output snap_busy, snap_valid, snap_val, hi_ovf);
endinterface

// File: rtl/cnt_ext_snap.sv
// cnt_ext_snap: chunk-pipelined high-word extension of a low counter with coherent {hi,lo} snapshots.
// Optional CNT_EXT_AUTO_SNAP_EN: every low-counter wrap also requests a snapshot.
module cnt_ext_snap #(
    parameter int N = 17,
    parameter int M = 32,
    parameter int W = 8
) (
    input logic clk,
    input logic reset,
    cnt_ext_snap_if.slave bus
);
    localparam int CHUNKS = M / W;
    localparam int JW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;

    typedef enum logic {IDLE, RESOLVE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]      h [CHUNKS];
    logic [W-1:0]      h_sum [CHUNKS];
    logic [CHUNKS-1:1] c_r;
    logic [CHUNKS-1:0] c, co;

    logic [N-1:0]      s_lo;
    logic [W-1:0]      s_h [CHUNKS];
    logic [CHUNKS-1:0] s_c;
    logic              r, rc, req, accept, last;
    logic [JW-1:0]     j;
    logic [W-1:0]      rs;
    logic [M-1:0]      hi_res;

    // c[0] is the live carry-in so a wrap in the capture cycle is never lost
    assign c = {c_r, bus.lo_cout};

    always_comb begin
        for (int i = 0; i < CHUNKS; i++)
            {co[i], h_sum[i]} = {1'b0, h[i]} + (W+1)'(c[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHUNKS; i++) h[i] <= '0;
            c_r        <= '0;
            bus.hi_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < CHUNKS; i++) h[i] <= h_sum[i];
            c_r <= co[CHUNKS-2:0];
            if (co[CHUNKS-1]) bus.hi_ovf <= 1'b1;
        end
    end

`ifdef CNT_EXT_AUTO_SNAP_EN
    assign req = bus.snap_req | bus.lo_cout;
`else
    assign req = bus.snap_req;
`endif

    assign accept        = state == IDLE && req && !bus.snap_valid;
    assign last          = j == JW'(CHUNKS - 1);
    assign bus.snap_busy = state == RESOLVE;
    assign {rc, rs}      = {1'b0, s_h[j]} + (W+1)'(s_c[j]) + (W+1)'(r);

    // chunks below j are already resolved; chunk j takes this cycle's sum
    always_comb begin
        for (int i = 0; i < CHUNKS; i++)
            hi_res[i*W +: W] = JW'(i) == j ? rs : s_h[i];
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (accept ? RESOLVE : IDLE) : (last ? IDLE : RESOLVE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_lo           <= '0;
            for (int i = 0; i < CHUNKS; i++) s_h[i] <= '0;
            s_c            <= '0;
            r              <= 1'b0;
            j              <= '0;
            bus.snap_valid <= 1'b0;
            bus.snap_val   <= '0;
        end else begin
            bus.snap_valid <= state == RESOLVE && last;
            if (accept) begin
                s_lo <= bus.lo_cnt;
                for (int i = 0; i < CHUNKS; i++) s_h[i] <= h[i];
                s_c  <= c;
                r    <= 1'b0;
                j    <= '0;
            end else if (state == RESOLVE) begin
                s_h[j] <= rs;
                r      <= rc;
                j      <= j + JW'(1);
                if (last) bus.snap_val <= {hi_res, s_lo};
            end
        end
    end
endmodule

// File: tb/tb_cnt_ext_snap.sv
// tb_cnt_ext_snap: directed table-driven bench for cnt_ext_snap plus multi-cycle corner sequences
module tb_cnt_ext_snap;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnt_ext_snap_if #(.N(17), .M(32)) bus ();
    cnt_ext_snap_if #(.N(17), .M(16)) bus2 ();

    cnt_ext_snap #(.N(17), .M(32), .W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    cnt_ext_snap #(.N(17), .M(16), .W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          rst;
        int          pulses;
        bit          cout;
        logic [16:0] lo;
        logic [48:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.snap_req = 1'b0; bus.lo_cout = 1'b0; bus.lo_cnt = '0;
        bus2.snap_req = 1'b0; bus2.lo_cout = 1'b0; bus2.lo_cnt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk); bus.lo_cout = 1'b1;
            @(negedge clk); bus.lo_cout = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic snap(input logic [16:0] lo, input logic cout, output logic [48:0] val,
                        output int bcnt, output int vcnt, output int vpos);
        @(negedge clk);
        bus.snap_req = 1'b1; bus.lo_cnt = lo; bus.lo_cout = cout;
        bcnt = 0; vcnt = 0; vpos = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.snap_req = 1'b0; bus.lo_cout = 1'b0; end
            bcnt += int'(bus.snap_busy);
            if (bus.snap_valid) begin vcnt++; vpos = n; end
        end
        val = bus.snap_val;
    endtask

    initial begin
        vec_t        v [5];
        logic [48:0] val, got;
        int          bcnt, vcnt, vpos, r;

        v[0] = '{1'b1, 0,   1'b0, 17'h0,     49'h0};
        v[1] = '{1'b0, 300, 1'b0, 17'h5,     49'h2580005};
        v[2] = '{1'b1, 255, 1'b1, 17'h0,     49'h2000000};
        v[3] = '{1'b0, 0,   1'b0, 17'h1FFFF, 49'h201FFFF};
        v[4] = '{1'b0, 1,   1'b1, 17'h3,     49'h2040003};

        reset = 1'b1;
        bus.snap_req = 1'b0; bus.lo_cout = 1'b0; bus.lo_cnt = '0;
        bus2.snap_req = 1'b0; bus2.lo_cout = 1'b0; bus2.lo_cnt = '0;
        do_reset();
        @(negedge clk);
        check("rst_busy", 64'(bus.snap_busy), 64'd0);
        check("rst_valid", 64'(bus.snap_valid), 64'd0);
        check("rst_val", 64'(bus.snap_val), 64'd0);
        check("rst_ovf", 64'(bus.hi_ovf), 64'd0);

        for (int i = 0; i < 5; i++) begin
            if (v[i].rst) do_reset();
            pulse(v[i].pulses);
            repeat (6) @(negedge clk);
            snap(v[i].lo, v[i].cout, val, bcnt, vcnt, vpos);
            check($sformatf("vec%0d_val", i), 64'(val), 64'(v[i].exp));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd4);
            check($sformatf("vec%0d_valid_count", i), 64'(vcnt), 64'd1);
            check($sformatf("vec%0d_valid_pos", i), 64'(vpos), 64'd5);
            check($sformatf("vec%0d_ovf", i), 64'(bus.hi_ovf), 64'd0);
        end

        // request held through busy and the valid cycle: one snapshot only
        @(negedge clk);
        bus.snap_req = 1'b1; bus.lo_cnt = 17'h7;
        vcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 6) bus.snap_req = 1'b0;
            if (bus.snap_valid) vcnt++;
        end
        check("hold_valid_count", 64'(vcnt), 64'd1);
        check("hold_val", 64'(bus.snap_val), 64'h2040007);

        // reset two cycles into a snapshot aborts it
        @(negedge clk); bus.snap_req = 1'b1; bus.lo_cnt = 17'h1;
        @(negedge clk); bus.snap_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        vcnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.snap_valid) vcnt++;
        end
        check("abort_valid_count", 64'(vcnt), 64'd0);
        check("abort_val", 64'(bus.snap_val), 64'd0);
        check("abort_busy", 64'(bus.snap_busy), 64'd0);
        check("abort_ovf", 64'(bus.hi_ovf), 64'd0);

`ifndef CNT_EXT_AUTO_SNAP_EN
        // back-to-back wraps with a request at a random cycle
        do_reset();
        r = int'($urandom_range(10, 989));
        vcnt = 0; got = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.snap_valid) begin vcnt++; got = bus.snap_val; end
            bus.lo_cout = 1'b1; bus.lo_cnt = '0;
            bus.snap_req = (i == r);
        end
        @(negedge clk);
        bus.lo_cout = 1'b0; bus.snap_req = 1'b0;
        if (bus.snap_valid) begin vcnt++; got = bus.snap_val; end
        check("b2b_valid_count", 64'(vcnt), 64'd1);
        check("b2b_hi", 64'(got[48:17]), 64'(r + 1));
        check("b2b_lo", 64'(got[16:0]), 64'd0);
        repeat (6) @(negedge clk);
        snap(17'h0, 1'b0, val, bcnt, vcnt, vpos);
        check("b2b_total", 64'(val), 64'd1000 << 17);
`endif

        // narrow instance: wrap of the 16-bit high word
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk); bus2.lo_cout = 1'b1;
        end
        @(negedge clk); bus2.lo_cout = 1'b0;
        repeat (6) @(negedge clk);
        check("ovf_before_wrap", 64'(bus2.hi_ovf), 64'd0);
        @(negedge clk); bus2.lo_cout = 1'b1;
        @(negedge clk); bus2.lo_cout = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_after_wrap", 64'(bus2.hi_ovf), 64'd1);
        @(negedge clk); bus2.snap_req = 1'b1; bus2.lo_cnt = 17'h9;
        vcnt = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus2.snap_req = 1'b0;
            if (bus2.snap_valid) vcnt++;
        end
        check("ovf_snap_valid_count", 64'(vcnt), 64'd1);
        check("ovf_snap_val", 64'(bus2.snap_val), 64'h9);
        check("ovf_sticky", 64'(bus2.hi_ovf), 64'd1);

`ifdef CNT_EXT_AUTO_SNAP_EN
        do_reset();
        @(negedge clk); bus.lo_cout = 1'b1; bus.lo_cnt = '0;
        vcnt = 0; vpos = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus.lo_cout = 1'b0;
            if (bus.snap_valid) begin vcnt++; vpos = n; end
        end
        check("auto_valid_count", 64'(vcnt), 64'd1);
        check("auto_valid_pos", 64'(vpos), 64'd5);
        check("auto_val", 64'(bus.snap_val), 64'd1 << 17);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
